rob_retire_buffer: RTL and testbench
====================================

Name: rob_retire_buffer

Overview:
- Reorder buffer sitting directly downstream of the execute wrapper.
- Allocates slots in program order to the issue side; the slot index travels with the instruction into execute.
- Accepts out-of-order result writeback from execute, indexed by slot.
- Retires completed entries strictly in order to the register-file write port.

Parameters:
ROB_DEPTHLOG2, 4, log2 of entry count; DEPTH = 2**ROB_DEPTHLOG2 entries.

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
alloc_req  in  1  request a slot this cycle
alloc_ready  out  1  slot available (not full)
alloc_slot  out  ROB_DEPTHLOG2  slot granted when alloc_req & alloc_ready
wb_valid  in  1  writeback strobe from execute
wb_idx  in  ROB_DEPTHLOG2  slot being written back
wb_result  in  32  result value
wb_dest_reg  in  5  destination register
wb_dest_reg_valid  in  1  destination write enabled
retire_valid  out  1  one entry retiring this cycle
retire_slot  out  ROB_DEPTHLOG2  slot of retiring entry
retire_result  out  32  retiring result
retire_dest_reg  out  5  retiring destination register
retire_dest_reg_valid  out  1  register-file write enable (already qualified by retire_valid)
count  out  ROB_DEPTHLOG2+1  occupied entries, 0..DEPTH
empty  out  1  count == 0

Behaviour:
- Storage: circular array of DEPTH entries; per entry: busy, done, result[31:0], dest_reg[4:0], dest_reg_valid.
- Pointers: head and tail, ROB_DEPTHLOG2+1 bits each, MSB is the wrap bit.
  - full = (head, tail low bits equal) and (wrap bits differ).
  - empty = (head == tail).
- alloc_ready = ~full, from registered state only; a retire in the same cycle does not free a slot for allocation until the next cycle.
- alloc_slot = tail low bits, combinational.
- Allocation, on an edge with alloc_req & alloc_ready:
  - entry[tail]: busy<=1, done<=0.
  - tail<=tail+1.
  - alloc_req while full is ignored; no state change.
- Writeback, on an edge with wb_valid:
  - If entry[wb_idx] is busy and not done: done<=1 and result, dest_reg, dest_reg_valid are stored.
  - Otherwise ignored. This covers a non-busy slot, an already-done slot, and a slot being allocated in the same cycle. The simulation-only assertion flags it.
- Retire, evaluated every edge:
  - If entry[head] is busy & done: retire_valid<=1; retire fields <= entry[head] fields; retire_slot<=head; entry[head].busy<=0, done<=0; head<=head+1.
  - Else retire_valid<=0.
  - Retire fields hold their last value when retire_valid=0.
  - retire_dest_reg_valid<=0 whenever retire_valid<=0.
  - At most one retire per cycle.
- Latency:
  - Writeback at edge N sets done.
  - Earliest retire is at edge N+1, so retire_valid is high in the cycle after edge N+1.
  - Minimum alloc-to-retire is 3 edges.
- Simultaneous events:
  - Allocation, writeback and retire may all occur on one edge, provided they target different entries.
  - Writeback to head on the same edge as a retire check: retire happens on the following edge.
  - count <= count + alloc_fire - retire_fire.
- Reset (synchronous, priority over all other activity, including mid-operation):
  - All busy/done cleared; head=tail=0; count=0.
  - Resulting outputs: empty=1, alloc_ready=1, alloc_slot=0, retire_valid=0, retire_slot=0, retire_result=0, retire_dest_reg=0, retire_dest_reg_valid=0.

Optional Feature:
- Macro: ROB_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit).
  - On an edge with flush=1: all busy/done cleared, head=tail=0, count=0, retire_valid<=0, retire_dest_reg_valid<=0.
  - flush has priority over alloc/writeback/retire on the same edge; reset has priority over flush.
  - Retire data fields are not cleared.
- Not defined: port absent; entries leave only via retire or reset.

Test Plan:
1. Assert reset 2 cycles, release -> alloc_ready=1, empty=1, count=0, alloc_slot=0, retire_valid=0.
2. Allocate slots 0,1,2; writeback idx2 result 0x22 dest 3, then idx0 0x00 dest 1, then idx1 0x11 dest 2 -> retires in order: slot0/0x00/r1, slot1/0x11/r2, slot2/0x22/r3, each with retire_dest_reg_valid=1.
3. Allocate 16 without writeback -> count=16, alloc_ready=0; a 17th alloc_req causes no change. Writeback and retire slot0 -> next cycle alloc_ready=1, alloc_slot=0 (wrap), count=15.
4. Stream 40 alloc/writeback/retire ops with random writeback order across pointer wrap -> retire_slot sequence 0..15,0..15,0..7; results match; no skips or duplicates.
5. Writeback slot with wb_dest_reg_valid=0, result 0xDEADBEEF -> retire_valid=1, retire_result=0xDEADBEEF, retire_dest_reg_valid=0. Writeback to an unallocated slot -> ignored, assertion fires.
6. With 5 pending and 2 done:
   - Reset mid-stream -> count=0, no retire, alloc_slot=0.
   - With ROB_FLUSH_EN, flush in place of reset -> identical outcome.

Source files
------------

// File: rtl/rob_retire_buffer.sv
// rob_retire_buffer
//   Reorder buffer between issue and the register file. Slots are handed out
//   in program order. Execute writes results back out of order, indexed by
//   slot. Completed entries retire strictly in order, at most one per cycle,
//   on a registered retire port.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   flush                  (only with ROB_FLUSH_EN) discard all entries
//   alloc_req/ready/slot   in-order slot allocation toward issue
//   wb_*                   out-of-order result writeback from execute
//   retire_*               registered in-order retire toward the register file
//   count, empty           occupancy
//
// Build option
//   ROB_FLUSH_EN  adds the flush input. When it is undefined, entries leave
//                 only through retire or reset.

module rob_retire_buffer #(
  parameter int ROB_DEPTHLOG2 = 4
) (
  input  logic                     clock,
  input  logic                     reset,
`ifdef ROB_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     alloc_req,
  output logic                     alloc_ready,
  output logic [ROB_DEPTHLOG2-1:0] alloc_slot,
  input  logic                     wb_valid,
  input  logic [ROB_DEPTHLOG2-1:0] wb_idx,
  input  logic [31:0]              wb_result,
  input  logic [4:0]               wb_dest_reg,
  input  logic                     wb_dest_reg_valid,
  output logic                     retire_valid,
  output logic [ROB_DEPTHLOG2-1:0] retire_slot,
  output logic [31:0]              retire_result,
  output logic [4:0]               retire_dest_reg,
  output logic                     retire_dest_reg_valid,
  output logic [ROB_DEPTHLOG2:0]   count,
  output logic                     empty
);

  localparam int DEPTH = 2 ** ROB_DEPTHLOG2;
  localparam int PW    = ROB_DEPTHLOG2 + 1;

  // Pointers carry an extra wrap bit so that full and empty can be told apart.
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;

  // The payload needs no reset because it is only read once done is set.
  logic [31:0]      result_q [DEPTH];
  logic [4:0]       dest_q   [DEPTH];
  logic [DEPTH-1:0] dvalid_q;

  logic                     rv_q, rv_d;
  logic [ROB_DEPTHLOG2-1:0] rslot_q, rslot_d;
  logic [31:0]              rres_q, rres_d;
  logic [4:0]               rdest_q, rdest_d;
  logic                     rdv_q, rdv_d;

  logic [ROB_DEPTHLOG2-1:0] head_idx, tail_idx;
  logic full, alloc_fire, wb_accept, retire_fire, flush_w;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign head_idx = head_q[ROB_DEPTHLOG2-1:0];
  assign tail_idx = tail_q[ROB_DEPTHLOG2-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[PW-1] != tail_q[PW-1]);

  // Only registered state is used here, so a retire on this edge cannot
  // make room for an allocation on the same edge.
  assign alloc_fire  = alloc_req & ~full;
  // The entry being allocated is never busy yet. That alone rejects a
  // writeback aimed at the slot that is being allocated on the same edge.
  assign wb_accept   = wb_valid & busy_q[wb_idx] & ~done_q[wb_idx];
  // done_q is used as registered, so a writeback to head on this edge
  // retires on the next edge.
  assign retire_fire = busy_q[head_idx] & done_q[head_idx];

  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_w) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // alloc, writeback and retire always touch different entries,
      // so the order of these updates does not matter.
      if (alloc_fire) begin
        busy_d[tail_idx] = 1'b1;
        done_d[tail_idx] = 1'b0;
        tail_d           = tail_q + PW'(1);
      end
      if (wb_accept) begin
        done_d[wb_idx] = 1'b1;
      end
      if (retire_fire) begin
        busy_d[head_idx] = 1'b0;
        done_d[head_idx] = 1'b0;
        head_d           = head_q + PW'(1);
      end
      count_d = count_q + PW'(alloc_fire) - PW'(retire_fire);
    end
  end

  // The retire data fields hold their value when nothing retires.
  always_comb begin
    rv_d    = retire_fire & ~flush_w;
    rslot_d = rslot_q;
    rres_d  = rres_q;
    rdest_d = rdest_q;
    rdv_d   = 1'b0;
    if (rv_d) begin
      rslot_d = head_idx;
      rres_d  = result_q[head_idx];
      rdest_d = dest_q[head_idx];
      rdv_d   = dvalid_q[head_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      rv_q    <= 1'b0;
      rslot_q <= '0;
      rres_q  <= '0;
      rdest_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      rslot_q <= rslot_d;
      rres_q  <= rres_d;
      rdest_q <= rdest_d;
      rdv_q   <= rdv_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wb_accept && !flush_w) begin
      result_q[wb_idx] <= wb_result;
      dest_q[wb_idx]   <= wb_dest_reg;
      dvalid_q[wb_idx] <= wb_dest_reg_valid;
    end
  end

  assign alloc_ready           = ~full;
  assign alloc_slot            = tail_idx;
  assign count                 = count_q;
  assign empty                 = (head_q == tail_q);
  assign retire_valid          = rv_q;
  assign retire_slot           = rslot_q;
  assign retire_result         = rres_q;
  assign retire_dest_reg       = rdest_q;
  assign retire_dest_reg_valid = rdv_q;

`ifndef SYNTHESIS
  // A writeback is expected to hit a slot that is busy and still waiting.
  // Anything else is dropped by the logic above. This check only reports it.
  wb_target_legal: assert property (@(posedge clock) disable iff (reset)
    wb_valid |-> (busy_q[wb_idx] && !done_q[wb_idx]))
    else $warning("rob_retire_buffer: writeback to slot %0d dropped (slot not busy or already done)", wb_idx);
`endif

endmodule

// File: tb/tb_rob_retire_buffer.sv
module tb_rob_retire_buffer;

  logic        clock;
  logic        reset;
`ifdef ROB_FLUSH_EN
  logic        flush;
`endif
  logic        alloc_req;
  logic        alloc_ready;
  logic [3:0]  alloc_slot;
  logic        wb_valid;
  logic [3:0]  wb_idx;
  logic [31:0] wb_result;
  logic [4:0]  wb_dest_reg;
  logic        wb_dest_reg_valid;
  logic        retire_valid;
  logic [3:0]  retire_slot;
  logic [31:0] retire_result;
  logic [4:0]  retire_dest_reg;
  logic        retire_dest_reg_valid;
  logic [4:0]  count;
  logic        empty;

  int tests  = 0;
  int failed = 0;

  rob_retire_buffer #(.ROB_DEPTHLOG2(4)) dut (
    .clock                 (clock),
    .reset                 (reset),
`ifdef ROB_FLUSH_EN
    .flush                 (flush),
`endif
    .alloc_req             (alloc_req),
    .alloc_ready           (alloc_ready),
    .alloc_slot            (alloc_slot),
    .wb_valid              (wb_valid),
    .wb_idx                (wb_idx),
    .wb_result             (wb_result),
    .wb_dest_reg           (wb_dest_reg),
    .wb_dest_reg_valid     (wb_dest_reg_valid),
    .retire_valid          (retire_valid),
    .retire_slot           (retire_slot),
    .retire_result         (retire_result),
    .retire_dest_reg       (retire_dest_reg),
    .retire_dest_reg_valid (retire_dest_reg_valid),
    .count                 (count),
    .empty                 (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        al;
    logic        wv;
    logic [3:0]  wi;
    logic [31:0] wr;
    logic [4:0]  wd;
    logic        wdv;
    logic        e_ready;
    logic [3:0]  e_aslot;
    logic [4:0]  e_count;
    logic        e_rv;
    logic [3:0]  e_rslot;
    logic [31:0] e_rres;
    logic [4:0]  e_rdest;
    logic        e_rdv;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input int al, input int wv, input int wi,
                              input logic [31:0] wr, input int wd, input int wdv,
                              input int er, input int eas, input int ec, input int erv,
                              input int ers, input logic [31:0] err, input int erd,
                              input int erdv);
    vec_t v;
    v.al = al[0]; v.wv = wv[0]; v.wi = wi[3:0]; v.wr = wr; v.wd = wd[4:0]; v.wdv = wdv[0];
    v.e_ready = er[0]; v.e_aslot = eas[3:0]; v.e_count = ec[4:0]; v.e_rv = erv[0];
    v.e_rslot = ers[3:0]; v.e_rres = err; v.e_rdest = erd[4:0]; v.e_rdv = erdv[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req = 1'b0; wb_valid = 1'b0; wb_idx = '0; wb_result = '0;
    wb_dest_reg = '0; wb_dest_reg_valid = 1'b0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " count"},       32'(count), 32'd0);
    chk({tag, " empty"},       32'(empty), 32'd1);
    chk({tag, " alloc_ready"}, 32'(alloc_ready), 32'd1);
    chk({tag, " alloc_slot"},  32'(alloc_slot), 32'd0);
    chk({tag, " retire_valid"}, 32'(retire_valid), 32'd0);
    chk({tag, " retire_dvalid"}, 32'(retire_dest_reg_valid), 32'd0);
  endtask

  task automatic setup_five_pending();
    do_reset();
    alloc_req = 1'b1;
    for (int i = 0; i < 5; i++) step();
    alloc_req = 1'b0;
    wb_valid = 1'b1; wb_idx = 4'd1; wb_result = 32'h61; wb_dest_reg = 5'd1; wb_dest_reg_valid = 1'b1;
    step();
    wb_idx = 4'd3; wb_result = 32'h63; wb_dest_reg = 5'd3;
    step();
    wb_valid = 1'b0;
    chk("pending5 count", 32'(count), 32'd5);
    chk("pending5 retire_valid", 32'(retire_valid), 32'd0);
    // Reset or flush lands with alloc and a legal writeback in flight.
    alloc_req = 1'b1;
    wb_valid = 1'b1; wb_idx = 4'd0; wb_result = 32'h60; wb_dest_reg = 5'd6;
  endtask

  initial begin
    int n_alloc;
    int n_ret;
    int pend[$];
    logic fire;

    reset = 1'b1;
    idle_inputs();

    // In order: al wv wi wr wd wdv | ready aslot count rv rslot rres rdest rdv
    vt[0]  = mk(1,0,0,32'h0,0,0,            1,1,1,0, 0,32'h0,0,0);
    vt[1]  = mk(1,0,0,32'h0,0,0,            1,2,2,0, 0,32'h0,0,0);
    vt[2]  = mk(1,0,0,32'h0,0,0,            1,3,3,0, 0,32'h0,0,0);
    vt[3]  = mk(0,1,2,32'h22,3,1,           1,3,3,0, 0,32'h0,0,0);
    vt[4]  = mk(0,1,0,32'h00,1,1,           1,3,3,0, 0,32'h0,0,0);
    vt[5]  = mk(0,1,1,32'h11,2,1,           1,3,2,1, 0,32'h00,1,1);
    vt[6]  = mk(0,0,0,32'h0,0,0,            1,3,1,1, 1,32'h11,2,1);
    vt[7]  = mk(0,0,0,32'h0,0,0,            1,3,0,1, 2,32'h22,3,1);
    vt[8]  = mk(0,0,0,32'h0,0,0,            1,3,0,0, 2,32'h22,3,0);
    vt[9]  = mk(1,0,0,32'h0,0,0,            1,4,1,0, 2,32'h22,3,0);
    vt[10] = mk(1,0,0,32'h0,0,0,            1,5,2,0, 2,32'h22,3,0);
    vt[11] = mk(0,1,4,32'hAAAA0004,5,1,     1,5,2,0, 2,32'h22,3,0);
    vt[12] = mk(0,1,4,32'hBBBB0004,6,0,     1,5,2,0, 2,32'h22,3,0);
    vt[13] = mk(0,1,3,32'hDEADBEEF,7,0,     1,5,2,0, 2,32'h22,3,0);
    vt[14] = mk(0,1,9,32'h55,4,1,           1,5,1,1, 3,32'hDEADBEEF,7,0);
    vt[15] = mk(0,0,0,32'h0,0,0,            1,5,0,1, 4,32'hAAAA0004,5,1);
    vt[16] = mk(1,0,0,32'h0,0,0,            1,6,1,0, 4,32'hAAAA0004,5,0);
    vt[17] = mk(0,0,0,32'h0,0,0,            1,6,1,0, 4,32'hAAAA0004,5,0);

    // Reset held for two cycles, then released.
    step(); step();
    reset = 1'b0;
    check_cleared("reset");
    chk("reset retire_slot",   32'(retire_slot), 32'd0);
    chk("reset retire_result", retire_result, 32'd0);
    chk("reset retire_dest",   32'(retire_dest_reg), 32'd0);

    // Table: in-order retire of out-of-order writebacks, then the no-dest
    // writeback and the ignored writebacks.
    for (int i = 0; i < 18; i++) begin
      alloc_req = vt[i].al; wb_valid = vt[i].wv; wb_idx = vt[i].wi;
      wb_result = vt[i].wr; wb_dest_reg = vt[i].wd; wb_dest_reg_valid = vt[i].wdv;
      step();
      chk($sformatf("vec%0d alloc_ready", i), 32'(alloc_ready), 32'(vt[i].e_ready));
      chk($sformatf("vec%0d alloc_slot", i),  32'(alloc_slot),  32'(vt[i].e_aslot));
      chk($sformatf("vec%0d count", i),       32'(count),       32'(vt[i].e_count));
      chk($sformatf("vec%0d empty", i),       32'(empty),       32'(vt[i].e_count == 5'd0));
      chk($sformatf("vec%0d retire_valid", i), 32'(retire_valid), 32'(vt[i].e_rv));
      chk($sformatf("vec%0d retire_slot", i), 32'(retire_slot), 32'(vt[i].e_rslot));
      chk($sformatf("vec%0d retire_result", i), retire_result, vt[i].e_rres);
      chk($sformatf("vec%0d retire_dest", i), 32'(retire_dest_reg), 32'(vt[i].e_rdest));
      chk($sformatf("vec%0d retire_dvalid", i), 32'(retire_dest_reg_valid), 32'(vt[i].e_rdv));
    end
    idle_inputs();

    // Fill to full; a 17th request is ignored. A retire does not free a
    // slot for allocation until the following cycle.
    do_reset();
    alloc_req = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("full count", 32'(count), 32'd16);
    chk("full alloc_ready", 32'(alloc_ready), 32'd0);
    chk("full empty", 32'(empty), 32'd0);
    step();
    chk("over-alloc count", 32'(count), 32'd16);
    chk("over-alloc alloc_slot", 32'(alloc_slot), 32'd0);
    wb_valid = 1'b1; wb_idx = 4'd0; wb_result = 32'h0F0F; wb_dest_reg = 5'd9; wb_dest_reg_valid = 1'b1;
    step();
    wb_valid = 1'b0;
    chk("full wb count", 32'(count), 32'd16);
    chk("full wb retire_valid", 32'(retire_valid), 32'd0);
    step();
    alloc_req = 1'b0;
    chk("full retire valid", 32'(retire_valid), 32'd1);
    chk("full retire slot", 32'(retire_slot), 32'd0);
    chk("full retire result", retire_result, 32'h0F0F);
    chk("after retire count", 32'(count), 32'd15);
    chk("after retire alloc_ready", 32'(alloc_ready), 32'd1);
    chk("after retire alloc_slot", 32'(alloc_slot), 32'd0);

    // 40 operations, writebacks in random order, across pointer wrap.
    do_reset();
    n_alloc = 0;
    n_ret = 0;
    for (int cyc = 0; cyc < 600 && n_ret < 40; cyc++) begin
      alloc_req = (n_alloc < 40);
      fire = alloc_req && alloc_ready;
      if (fire) chk("stream alloc_slot", 32'(alloc_slot), 32'(n_alloc % 16));
      if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
        int k;
        int op;
        k = int'($urandom_range(0, pend.size() - 1));
        op = pend[k];
        pend.delete(k);
        wb_valid = 1'b1; wb_idx = op[3:0]; wb_result = 32'h1000_0000 + op;
        wb_dest_reg = op[4:0]; wb_dest_reg_valid = 1'b1;
      end else begin
        wb_valid = 1'b0;
      end
      step();
      if (fire) begin
        pend.push_back(n_alloc);
        n_alloc++;
      end
      if (retire_valid) begin
        chk("stream retire_slot",   32'(retire_slot), 32'(n_ret % 16));
        chk("stream retire_result", retire_result, 32'h1000_0000 + n_ret);
        chk("stream retire_dest",   32'(retire_dest_reg), 32'(n_ret % 32));
        chk("stream retire_dvalid", 32'(retire_dest_reg_valid), 32'd1);
        n_ret++;
      end
    end
    idle_inputs();
    chk("stream retired total", 32'(n_ret), 32'd40);
    step();
    chk("stream drained count", 32'(count), 32'd0);
    chk("stream drained empty", 32'(empty), 32'd1);

    // Reset mid-stream, with 5 pending and 2 done.
    setup_five_pending();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    check_cleared("midreset");
    chk("midreset retire_slot", 32'(retire_slot), 32'd0);
    chk("midreset retire_result", retire_result, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midreset quiet retire_valid", 32'(retire_valid), 32'd0);
      chk("midreset quiet count", 32'(count), 32'd0);
    end
    alloc_req = 1'b1;
    step();
    alloc_req = 1'b0;
    chk("midreset realloc slot", 32'(alloc_slot), 32'd1);
    chk("midreset realloc count", 32'(count), 32'd1);

`ifdef ROB_FLUSH_EN
    setup_five_pending();
    flush = 1'b1;
    step();
    idle_inputs();
    check_cleared("flush");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush quiet retire_valid", 32'(retire_valid), 32'd0);
      chk("flush quiet count", 32'(count), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
